// File: rtl/lcd_char_responder_pkg.sv
// lcd_char_responder_pkg: opcode masks, bus bit indices, FSM states and blank character for the LCD responder
package lcd_char_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLEARING = 2'd2} state_t;
  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam int ENTRY_ID_BIT = 1;
  localparam int DISP_D_BIT   = 2;
  localparam int RS_BIT = 1;
  localparam int RW_BIT = 0;
  localparam logic [7:0] BLANK = 8'h20;
endpackage

// File: rtl/lcd_char_responder_ddram.sv
// lcd_char_responder_ddram: character RAM with one sync write, async cursor read and registered scan read
module lcd_char_responder_ddram #(
  parameter int DEPTH  = 80,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [7:0]        scan_data
);
  logic [7:0] mem [DEPTH];
  assign rdata = mem[raddr];
  // single write port shared by bus data writes and the clear sweep
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // scanner read, addresses past the end read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_data <= '0;
    else scan_data <= (32'(scan_addr) < DEPTH) ? mem[scan_addr] : 8'h00;
  end
endmodule

// File: rtl/lcd_char_responder.sv
// lcd_char_responder: HD44780-style device end of the LCD bus; LCD_SIM_PRINT_EN mirrors written characters to the console
module lcd_char_responder
  import lcd_char_responder_pkg::*;
#(
  parameter int DEPTH       = 80,
  parameter int ADDR_W      = 7,
  parameter int BUSY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        lcd_data,
  input  logic [1:0]        lcd_ctrl,
  input  logic              lcd_enable,
  output logic [7:0]        lcd_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor,
  output logic              display_on,
  output logic              char_valid,
  output logic [7:0]        char_data,
  output logic              overrun,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [7:0]        scan_data
);
  localparam int CW = $clog2(BUSY_CYCLES + 1);
  state_t state;
  logic en_q, inc, rs, rw, fall, idle, wr_fall, rd_fall, acc, acc_data, acc_clr;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] clr_idx, cur_next;
  logic [7:0] ram_rd;
  assign rs       = lcd_ctrl[RS_BIT];
  assign rw       = lcd_ctrl[RW_BIT];
  assign fall     = en_q & ~lcd_enable;
  assign idle     = state == IDLE;
  assign busy     = ~idle;
  assign wr_fall  = fall & ~rw;
  assign rd_fall  = fall & rw & rs;
  assign acc      = wr_fall & idle & (rs | (lcd_data != 8'h00));
  assign acc_data = acc & rs;
  assign acc_clr  = acc & ~rs & (lcd_data == CMD_CLR);
  assign cur_next = inc ? ((cursor == ADDR_W'(DEPTH - 1)) ? '0 : cursor + ADDR_W'(1))
                        : ((cursor == '0) ? ADDR_W'(DEPTH - 1) : cursor - ADDR_W'(1));
  assign lcd_rdata = (lcd_enable & rw) ? (rs ? ram_rd : {busy, 7'(cursor)}) : 8'h00;

  lcd_char_responder_ddram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ddram (
    .clk(clk),
    .rst_n(rst_n),
    .we(acc_data | (state == CLEARING)),
    .waddr(acc_data ? cursor : clr_idx),
    .wdata(acc_data ? lcd_data : BLANK),
    .raddr(cursor),
    .rdata(ram_rd),
    .scan_addr(scan_addr),
    .scan_data(scan_data)
  );

  // busy sequencing: power-on/command clear sweep and post-write countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEARING;
      clr_idx <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          state   <= acc_clr ? CLEARING : EXEC;
          cnt     <= CW'(BUSY_CYCLES);
          clr_idx <= '0;
        end
        EXEC: if (cnt == CW'(1)) state <= IDLE; else cnt <= cnt - CW'(1);
        CLEARING: if (clr_idx == ADDR_W'(DEPTH - 1)) state <= IDLE; else clr_idx <= clr_idx + ADDR_W'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // bus edge detect, command decode, cursor movement and character strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      cursor     <= '0;
      inc        <= 1'b1;
      display_on <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      en_q       <= lcd_enable;
      char_valid <= acc_data;
      if (acc_data) char_data <= lcd_data;
      if (wr_fall & ~idle) overrun <= 1'b1;
      if (acc_data | rd_fall) cursor <= cur_next;
      else if (acc & ~rs) begin
        if (|(lcd_data & CMD_DDRAM)) cursor <= (32'(lcd_data[6:0]) >= DEPTH) ? '0 : ADDR_W'(lcd_data[6:0]);
        else if (!(|(lcd_data & (CMD_CGRAM | CMD_FUNC | CMD_SHIFT)))) begin
          if (|(lcd_data & CMD_DISP)) display_on <= lcd_data[DISP_D_BIT];
          else if (|(lcd_data & CMD_ENTRY)) inc <= lcd_data[ENTRY_ID_BIT];
          else if (|(lcd_data & CMD_HOME)) cursor <= '0;
          else begin
            cursor <= '0;
            inc    <= 1'b1;
          end
        end
      end
    end
  end

`ifdef LCD_SIM_PRINT_EN
  // console mirror of accepted characters, newline on clear
  always_ff @(posedge clk) begin
    if (rst_n && acc_data) $write("%c", lcd_data);
    else if (rst_n && acc_clr) $write("\n");
  end
`else
`endif
endmodule

// File: tb/tb_lcd_char_responder.sv
// tb_lcd_char_responder: scoreboard bench for the LCD character responder
module tb_lcd_char_responder;
  localparam int DEPTH = 80, ADDR_W = 7, BUSY_CYCLES = 4;
  logic clk = 0, rst_n = 0, lcd_enable = 0;
  logic [7:0] lcd_data = 0;
  logic [1:0] lcd_ctrl = 0;
  logic [ADDR_W-1:0] scan_addr = 0;
  logic [7:0] lcd_rdata, char_data, scan_data;
  logic busy, display_on, char_valid, overrun;
  logic [ADDR_W-1:0] cursor;
  int total = 0, bad = 0;
  logic [7:0] q_char[$];
  logic [7:0] q_rd[$];

  always #5 clk = ~clk;

  lcd_char_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_CYCLES(BUSY_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl), .lcd_enable(lcd_enable),
    .lcd_rdata(lcd_rdata), .busy(busy), .cursor(cursor), .display_on(display_on),
    .char_valid(char_valid), .char_data(char_data), .overrun(overrun),
    .scan_addr(scan_addr), .scan_data(scan_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (char_valid) begin
      if (q_char.size() == 0) begin
        total++; bad++;
        $display("FAIL char_extra: got 0x%0h expected no character", char_data);
      end else check("char_data", char_data, q_char.pop_front());
    end
    if (lcd_enable && lcd_ctrl[0]) begin
      if (q_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL rdata_extra: got 0x%0h expected no read", lcd_rdata);
      end else check("lcd_rdata", lcd_rdata, q_rd.pop_front());
    end
  end

  task automatic bus_op(input logic [1:0] ctrl, input logic [7:0] d);
    @(negedge clk); lcd_ctrl = ctrl; lcd_data = d; lcd_enable = 1;
    @(negedge clk); lcd_enable = 0;
    @(negedge clk); lcd_ctrl = 0; lcd_data = 0;
  endtask

  task automatic wr_data(input logic [7:0] d);
    q_char.push_back(d);
    bus_op(2'b10, d);
  endtask

  task automatic wr_cmd(input logic [7:0] d);
    bus_op(2'b00, d);
  endtask

  task automatic rd(input logic rs, input logic [7:0] exp);
    q_rd.push_back(exp);
    bus_op({rs, 1'b1}, 8'h00);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 500) begin n++; @(negedge clk); end
  endtask

  task automatic wait_idle;
    int n;
    count_busy(n);
    check("idle_timeout", busy, 0);
  endtask

  task automatic scan(input int a, output logic [7:0] v);
    @(negedge clk); scan_addr = ADDR_W'(a);
    @(negedge clk); v = scan_data;
  endtask

  task automatic check_reset_outputs;
    check("rst_busy", busy, 1);
    check("rst_cursor", cursor, 0);
    check("rst_display_on", display_on, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_data", char_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_scan_data", scan_data, 0);
  endtask

  task automatic check_all_blank;
    logic [7:0] v;
    for (int a = 0; a < DEPTH; a++) begin
      scan(a, v);
      check($sformatf("blank_%0d", a), v, 8'h20);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    check("rst_rdata", lcd_rdata, 0);
    rst_n = 1;
    count_busy(n);
    check("por_busy_cycles", n, DEPTH);
    check_all_blank();

    wr_data(8'h48);
    count_busy(n);
    check("write_busy_cycles", n, BUSY_CYCLES);
    wr_data(8'h69);
    wait_idle();
    check("cursor_after_hi", cursor, 2);
    scan(0, v); check("ram0_H", v, 8'h48);
    scan(1, v); check("ram1_i", v, 8'h69);

    wr_cmd(8'h00);
    check("nop_not_busy", busy, 0);
    wr_cmd(8'h0C); wait_idle();
    check("display_on", display_on, 1);

    wr_cmd(8'hCF); wait_idle();
    check("cursor_set79", cursor, 79);
    wr_data(8'h5A); wait_idle();
    check("cursor_wrap_up", cursor, 0);
    scan(79, v); check("ram79_Z", v, 8'h5A);
    wr_cmd(8'h04); wait_idle();
    wr_data(8'h41); wait_idle();
    check("cursor_wrap_down", cursor, 79);
    scan(0, v); check("ram0_A", v, 8'h41);
    wr_cmd(8'h06); wait_idle();
    wr_cmd(8'hE4); wait_idle();
    check("cursor_out_of_range", cursor, 0);
    wr_cmd(8'h85); wait_idle();
    check("cursor_set5", cursor, 5);
    wr_cmd(8'h02); wait_idle();
    check("cursor_home", cursor, 0);
    wr_cmd(8'h14);
    check("shift_busy", busy, 1);
    wait_idle();
    check("shift_no_move", cursor, 0);
    wr_cmd(8'h08); wait_idle();
    check("display_off", display_on, 0);

    check("overrun_clear", overrun, 0);
    wr_data(8'h51);
    bus_op(2'b10, 8'h58);
    wait_idle();
    check("overrun_set", overrun, 1);
    check("cursor_after_drop", cursor, 1);
    scan(0, v); check("ram0_Q", v, 8'h51);
    scan(1, v); check("ram1_kept", v, 8'h69);

    wr_cmd(8'h01);
    rd(1'b0, 8'h80);
    wait_idle();
    check("overrun_sticky", overrun, 1);
    rd(1'b1, 8'h20);
    check("cursor_after_read", cursor, 1);
    rd(1'b0, 8'h01);
    scan(0, v); check("ram0_cleared", v, 8'h20);

    wr_cmd(8'hCF); wait_idle();
    wr_data(8'h57); wait_idle();
    check("cursor_before_reclear", cursor, 0);
    wr_cmd(8'h01);
    repeat (30) @(negedge clk);
    rst_n = 0;
    #1;
    check_reset_outputs();
    @(negedge clk); rst_n = 1;
    count_busy(n);
    check("reclear_busy_cycles", n, DEPTH);
    check_all_blank();

    repeat (3) @(negedge clk);
    check("char_queue_empty", q_char.size(), 0);
    check("read_queue_empty", q_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
